multi_expect_chk: RTL and testbench
===================================

Name: multi_expect_chk

Overview:
- Synthesisable, multi-channel successor to a single clocked `expect (a == b)` check.
- Each channel is armed by a control pulse. It then waits up to a programmable number of clocks for its two operands to match, and reports a one-cycle pass or fail pulse.
- Aggregate saturating pass/fail counters allow software or a testbench scoreboard to poll results.
- Sits beside datapath blocks as an in-silicon self-check monitor.

Parameters:
- NCH, 4: number of independent check channels (1..32).
- WIDTH, 32: operand width per channel.
- MAX_WAIT, 15: largest legal wait window in clocks; WW = $clog2(MAX_WAIT+1).
- CNT_W, 16: width of the aggregate pass/fail counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- arm_i  in  NCH  per-channel start pulse, sampled at posedge.
- win_i  in  WW  wait window captured at arm; values > MAX_WAIT are clamped to MAX_WAIT.
- a_i  in  NCH*WIDTH  channel c operand A at bits [c*WIDTH +: WIDTH].
- b_i  in  NCH*WIDTH  channel c operand B, same packing.
- clr_i  in  1  synchronous clear of both counters.
- busy_o  out  NCH  channel waiting.
- pass_o  out  NCH  one-cycle pass pulse.
- fail_o  out  NCH  one-cycle fail (timeout) pulse.
- rearm_err_o  out  NCH  one-cycle pulse: arm seen while channel busy.
- pass_cnt_o  out  CNT_W  total passes, saturating.
- fail_cnt_o  out  CNT_W  total fails, saturating.

Behaviour:
- Reset values: all outputs are 0; every channel FSM is IDLE; internal wait counters are 0.
- Per-channel FSM states are IDLE and WAIT.
- IDLE:
  - arm_i[c] high at edge k: go to WAIT and load cnt = min(win_i, MAX_WAIT).
  - busy_o[c] is 1 from edge k.
- WAIT, evaluated at each edge, highest priority first:
  1. a==b → pass_o[c]=1 for one cycle; return to IDLE.
  2. Else if cnt==0 → fail_o[c]=1 for one cycle; return to IDLE.
  3. Else cnt decrements.
- Timing:
  - The first compare happens at edge k+1, never in the arming cycle.
  - A window of W gives W+1 compare attempts, at edges k+1..k+1+W.
  - Pass/fail pulses are registered: they go high after the deciding edge and busy_o drops at the same edge.
- Arm while in WAIT, including at the deciding edge:
  - The arm is dropped and rearm_err_o[c] pulses one cycle.
  - The in-flight check is unaffected.
- Back-to-back checks: an arm in the cycle immediately after a pass/fail pulse is accepted normally.
- Counters:
  - At each edge, pass_cnt += popcount of the next-state pass vector (fail_cnt likewise), so the count is visible in the same cycle as the pulses.
  - Width of the addition is CNT_W+1; the result saturates at all-ones.
  - clr_i has priority over increments in the same cycle; the counters go to 0 and that edge's pulses are not counted.
- Equality compares the full WIDTH bits. X/Z on operands is not modelled in RTL.
- Reset asserted mid-check aborts all checks immediately. No pulse is generated, and the counters clear.

Optional Feature:
- Macro: MULTI_EXPECT_STICKY_FAIL_EN.
- Defined:
  - The first fail on any channel sets output fail_latch_o (1 bit) and captures fail_ch_o ($clog2(NCH) bits; lowest index wins on simultaneous fails).
  - While latched, all subsequent arms are blocked ("execution blocked"). A blocked arm raises rearm_err_o.
  - The latch is cleared only by clr_i or reset.
- Undefined: these ports do not exist, and arming is never blocked.

Decomposition:
- Package multi_expect_pkg:
  - chan_state_e enum {IDLE, WAIT}.
  - Function popcount(NCH-bit) returning CNT_W+1 bits.
  - Saturating add function.
- Sub-module expect_chk_chan: one channel FSM with its wait counter, compare and pulse registers, instantiated NCH times under generate.
- Top level: operand unpacking, counters, optional sticky logic.

Test Plan:
- Basic pass: ch0 arm with win=0 and a=b=5 at edge k+1 → pass_o[0] pulses for one cycle after k+1; pass_cnt=1; busy_o[0] high for one cycle.
- Timeout: ch1 arm with win=3, a=4, b=5 held → fail_o[1] after the 4th compare edge (k+4); fail_cnt=1; no pass.
- Late match: ch2 arm with win=5, a=5, b=6 until k+3, then b=5 → pass at k+3; pass_cnt increments by 1.
- Concurrent checks: all 4 channels armed with win=0, a==b on ch0/ch2 only → pass_o=4'b0101, fail_o=4'b1010, both counters +2 in the same cycle.
- Rearm and saturation: re-arm ch0 while busy → rearm_err_o[0] pulse, original result intact. With CNT_W=4, after 20 passes → pass_cnt stays at 15. Then clr_i together with a pass → counter reads 0.
- Reset and sticky: rst_n low mid-WAIT → outputs 0 and no pulse. With STICKY_FAIL_EN defined, a ch3 fail → fail_latch_o=1 and fail_ch_o=3; a subsequent ch0 arm → rearm_err_o[0] and no busy.

Source files
------------

// File: rtl/multi_expect_pkg.sv
// -----------------------------------------------------------------------------
// multi_expect_pkg
// Shared types and helpers for the multi-channel expect checker.
//   chan_state_e : per-channel FSM state (IDLE / WAIT)
//   popcount     : number of set bits in a channel vector (up to MAX_NCH bits)
//   sat_add      : add with saturation at the all-ones value of a w-bit counter
// Helpers are sized for the largest supported configuration; callers
// zero-extend their operands and truncate the result to their own width.
// -----------------------------------------------------------------------------
package multi_expect_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

    localparam int MAX_NCH   = 32;
    localparam int CNT_W_MAX = 32;
    localparam int SUM_W     = CNT_W_MAX + 2;

    // Count of set bits; result is CNT_W_MAX+1 bits wide.
    function automatic logic [CNT_W_MAX:0] popcount(input logic [MAX_NCH-1:0] v);
        logic [CNT_W_MAX:0] n;
        n = '0;
        for (int i = 0; i < MAX_NCH; i++) begin
            n = n + {{CNT_W_MAX{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // cur + inc, clamped to (2**w)-1. Intermediate sum is wide enough that it
    // can never wrap for any w <= CNT_W_MAX.
    function automatic logic [CNT_W_MAX-1:0] sat_add(
        input logic [CNT_W_MAX-1:0] cur,
        input logic [CNT_W_MAX:0]   inc,
        input int unsigned          w
    );
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] lim;
        sum = {2'b00, cur} + {1'b0, inc};
        lim = ({{(SUM_W-1){1'b0}}, 1'b1} << w) - {{(SUM_W-1){1'b0}}, 1'b1};
        if (sum > lim) begin
            return lim[CNT_W_MAX-1:0];
        end else begin
            return sum[CNT_W_MAX-1:0];
        end
    endfunction

endpackage

// File: rtl/multi_expect_chk_chan.sv
// -----------------------------------------------------------------------------
// expect_chk_chan
// One check channel: armed by a pulse, then compares a/b on every following
// clock until they match (pass) or the loaded window is exhausted (fail).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   arm                 start pulse
//   block               when high an arm in IDLE is refused (reported as rearm_err)
//   win                 wait window, clamped to MAX_WAIT when captured
//   a, b                operands, compared over the full WIDTH
//   busy                registered: channel is waiting
//   pass, fail          registered one-cycle result pulses
//   rearm_err           registered one-cycle pulse: arm refused
//   pass_nxt, fail_nxt  combinational next-state pulse values (for counting)
// -----------------------------------------------------------------------------
module expect_chk_chan
    import multi_expect_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 15,
    parameter int WW       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             block,
    input  logic [WW-1:0]    win,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             rearm_err,
    output logic             pass_nxt,
    output logic             fail_nxt
);

    localparam logic [WW-1:0] MAX_WAIT_W = WW'(MAX_WAIT);
    localparam logic [WW-1:0] ONE_W      = WW'(1);

    chan_state_e   state_r;
    chan_state_e   state_s;
    logic [WW-1:0] cnt_r;
    logic [WW-1:0] cnt_s;
    logic          busy_r;
    logic          pass_r;
    logic          fail_r;
    logic          rerr_r;
    logic          pass_s;
    logic          fail_s;
    logic          rerr_s;

    // Next-state decision: match beats timeout, timeout beats decrement.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pass_s  = 1'b0;
        fail_s  = 1'b0;
        rerr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (arm) begin
                    if (block) begin
                        rerr_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = (win > MAX_WAIT_W) ? MAX_WAIT_W : win;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                // An arm during WAIT (even on the deciding edge) is dropped.
                rerr_s = arm;
                if (a == b) begin
                    pass_s  = 1'b1;
                    state_s = IDLE;
                end else if (cnt_r == '0) begin
                    fail_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - ONE_W;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
            rerr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == WAIT);
            pass_r  <= pass_s;
            fail_r  <= fail_s;
            rerr_r  <= rerr_s;
        end
    end

    assign busy      = busy_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign rearm_err = rerr_r;
    assign pass_nxt  = pass_s;
    assign fail_nxt  = fail_s;

endmodule

// File: rtl/multi_expect_chk.sv
// -----------------------------------------------------------------------------
// multi_expect_chk
// NCH independent expect-style check channels with aggregate saturating
// pass/fail counters.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   arm_i[NCH]      per-channel start pulse
//   win_i[WW]       wait window captured at arm (clamped to MAX_WAIT)
//   a_i, b_i        operands, channel c at [c*WIDTH +: WIDTH]
//   clr_i           synchronous clear of both counters (wins over increments)
//   busy_o          channel waiting
//   pass_o, fail_o  one-cycle result pulses
//   rearm_err_o     one-cycle pulse: arm refused (busy, or blocked)
//   pass_cnt_o      total passes, saturating
//   fail_cnt_o      total fails, saturating
// Optional (macro MULTI_EXPECT_STICKY_FAIL_EN):
//   fail_latch_o    set by the first fail, blocks all later arms
//   fail_ch_o       channel of that first fail (lowest index on a tie)
//   Both are cleared only by clr_i or reset.
// -----------------------------------------------------------------------------
module multi_expect_chk
    import multi_expect_pkg::*;
#(
    parameter int  NCH      = 4,
    parameter int  WIDTH    = 32,
    parameter int  MAX_WAIT = 15,
    parameter int  CNT_W    = 16,
    localparam int WW       = $clog2(MAX_WAIT + 1),
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     arm_i,
    input  logic [WW-1:0]      win_i,
    input  logic [NCH*WIDTH-1:0] a_i,
    input  logic [NCH*WIDTH-1:0] b_i,
    input  logic               clr_i,
    output logic [NCH-1:0]     busy_o,
    output logic [NCH-1:0]     pass_o,
    output logic [NCH-1:0]     fail_o,
    output logic [NCH-1:0]     rearm_err_o,
`ifdef MULTI_EXPECT_STICKY_FAIL_EN
    output logic               fail_latch_o,
    output logic [CHW-1:0]     fail_ch_o,
`endif
    output logic [CNT_W-1:0]   pass_cnt_o,
    output logic [CNT_W-1:0]   fail_cnt_o
);

    logic [NCH-1:0]       pass_nxt_s;
    logic [NCH-1:0]       fail_nxt_s;
    logic                 block_s;
    logic [CNT_W_MAX:0]   pass_inc_s;
    logic [CNT_W_MAX:0]   fail_inc_s;
    logic [CNT_W-1:0]     pass_cnt_r;
    logic [CNT_W-1:0]     fail_cnt_r;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        expect_chk_chan #(
            .WIDTH    (WIDTH),
            .MAX_WAIT (MAX_WAIT),
            .WW       (WW)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .arm       (arm_i[g]),
            .block     (block_s),
            .win       (win_i),
            .a         (a_i[g*WIDTH +: WIDTH]),
            .b         (b_i[g*WIDTH +: WIDTH]),
            .busy      (busy_o[g]),
            .pass      (pass_o[g]),
            .fail      (fail_o[g]),
            .rearm_err (rearm_err_o[g]),
            .pass_nxt  (pass_nxt_s[g]),
            .fail_nxt  (fail_nxt_s[g])
        );
    end

    // Count the pulses being produced at this edge so counts and pulses line up.
    assign pass_inc_s = popcount(MAX_NCH'(pass_nxt_s));
    assign fail_inc_s = popcount(MAX_NCH'(fail_nxt_s));

    // Aggregate saturating counters; clear takes priority over this edge's pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
        end else if (clr_i) begin
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
        end else begin
            pass_cnt_r <= CNT_W'(sat_add(CNT_W_MAX'(pass_cnt_r), pass_inc_s, CNT_W));
            fail_cnt_r <= CNT_W'(sat_add(CNT_W_MAX'(fail_cnt_r), fail_inc_s, CNT_W));
        end
    end

    assign pass_cnt_o = pass_cnt_r;
    assign fail_cnt_o = fail_cnt_r;

`ifdef MULTI_EXPECT_STICKY_FAIL_EN
    logic           fail_latch_r;
    logic [CHW-1:0] fail_ch_r;
    logic [CHW-1:0] first_fail_s;

    // Lowest-index channel among this edge's fails.
    always_comb begin
        first_fail_s = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (fail_nxt_s[i]) begin
                first_fail_s = CHW'(i);
            end else begin
                first_fail_s = first_fail_s;
            end
        end
    end

    // Sticky first-fail latch; only the first fail after a clear is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_latch_r <= 1'b0;
            fail_ch_r    <= '0;
        end else if (clr_i) begin
            fail_latch_r <= 1'b0;
            fail_ch_r    <= '0;
        end else if (!fail_latch_r && (|fail_nxt_s)) begin
            fail_latch_r <= 1'b1;
            fail_ch_r    <= first_fail_s;
        end else begin
            fail_latch_r <= fail_latch_r;
            fail_ch_r    <= fail_ch_r;
        end
    end

    assign block_s      = fail_latch_r;
    assign fail_latch_o = fail_latch_r;
    assign fail_ch_o    = fail_ch_r;
`else
    assign block_s = 1'b0;
`endif

endmodule

// File: tb/tb_multi_expect_chk.sv
// -----------------------------------------------------------------------------
// Bench for multi_expect_chk (NCH=4, WIDTH=32, MAX_WAIT=15, CNT_W=4).
// The reference model tracks, per channel, the edge at which it was armed and
// its window; a check passes on the first edge in arm+1..arm+1+W where the
// operands are equal and fails at arm+1+W otherwise.
// -----------------------------------------------------------------------------
module tb_multi_expect_chk;

    localparam int NCH      = 4;
    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;
    localparam int WW       = 4;
    localparam int SAT      = 15;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       arm_i;
    logic [WW-1:0]        win_i;
    logic [NCH*WIDTH-1:0] a_i;
    logic [NCH*WIDTH-1:0] b_i;
    logic                 clr_i;
    logic [NCH-1:0]       busy_o;
    logic [NCH-1:0]       pass_o;
    logic [NCH-1:0]       fail_o;
    logic [NCH-1:0]       rearm_err_o;
    logic [CNT_W-1:0]     pass_cnt_o;
    logic [CNT_W-1:0]     fail_cnt_o;
`ifdef MULTI_EXPECT_STICKY_FAIL_EN
    logic                 fail_latch_o;
    logic [1:0]           fail_ch_o;
`endif

    multi_expect_chk #(
        .NCH      (NCH),
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm_i        (arm_i),
        .win_i        (win_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .clr_i        (clr_i),
        .busy_o       (busy_o),
        .pass_o       (pass_o),
        .fail_o       (fail_o),
        .rearm_err_o  (rearm_err_o),
`ifdef MULTI_EXPECT_STICKY_FAIL_EN
        .fail_latch_o (fail_latch_o),
        .fail_ch_o    (fail_ch_o),
`endif
        .pass_cnt_o   (pass_cnt_o),
        .fail_cnt_o   (fail_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Reference model state
    int             edge_n;
    bit             m_active   [NCH];
    int             m_arm_edge [NCH];
    int             m_w        [NCH];
    bit             m_latched;
    int             m_fail_ch;
    int             m_pcnt;
    int             m_fcnt;
    logic [NCH-1:0] e_busy;
    logic [NCH-1:0] e_pass;
    logic [NCH-1:0] e_fail;
    logic [NCH-1:0] e_rerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_active[c] = 1'b0;
        end
        m_latched = 1'b0;
        m_fail_ch = 0;
        m_pcnt    = 0;
        m_fcnt    = 0;
        e_busy    = '0;
        e_pass    = '0;
        e_fail    = '0;
        e_rerr    = '0;
    endtask

    // Predict outputs after the coming edge from the inputs currently applied.
    task automatic model_edge();
        int np;
        int nf;
        int w;
        bit eq;
        edge_n++;
        e_pass = '0;
        e_fail = '0;
        e_rerr = '0;
        for (int c = 0; c < NCH; c++) begin
            eq = (a_i[c*WIDTH +: WIDTH] == b_i[c*WIDTH +: WIDTH]);
            if (m_active[c]) begin
                if (arm_i[c]) e_rerr[c] = 1'b1;
                if (eq) begin
                    e_pass[c]   = 1'b1;
                    m_active[c] = 1'b0;
                end else if (edge_n == m_arm_edge[c] + 1 + m_w[c]) begin
                    e_fail[c]   = 1'b1;
                    m_active[c] = 1'b0;
                end
            end else if (arm_i[c]) begin
`ifdef MULTI_EXPECT_STICKY_FAIL_EN
                if (m_latched) begin
                    e_rerr[c] = 1'b1;
                end else
`endif
                begin
                    w = int'(win_i);
                    if (w > MAX_WAIT) w = MAX_WAIT;
                    m_active[c]   = 1'b1;
                    m_arm_edge[c] = edge_n;
                    m_w[c]        = w;
                end
            end
            e_busy[c] = m_active[c];
        end
        np = $countones(e_pass);
        nf = $countones(e_fail);
`ifdef MULTI_EXPECT_STICKY_FAIL_EN
        if (clr_i) begin
            m_latched = 1'b0;
            m_fail_ch = 0;
        end else if (!m_latched && nf != 0) begin
            m_latched = 1'b1;
            for (int c = NCH - 1; c >= 0; c--) if (e_fail[c]) m_fail_ch = c;
        end
`endif
        if (clr_i) begin
            m_pcnt = 0;
            m_fcnt = 0;
        end else begin
            m_pcnt = (m_pcnt + np > SAT) ? SAT : m_pcnt + np;
            m_fcnt = (m_fcnt + nf > SAT) ? SAT : m_fcnt + nf;
        end
    endtask

    task automatic check_all();
        chk("busy", 64'(busy_o), 64'(e_busy));
        chk("pass", 64'(pass_o), 64'(e_pass));
        chk("fail", 64'(fail_o), 64'(e_fail));
        chk("rearm_err", 64'(rearm_err_o), 64'(e_rerr));
        chk("pass_cnt", 64'(pass_cnt_o), 64'(m_pcnt));
        chk("fail_cnt", 64'(fail_cnt_o), 64'(m_fcnt));
`ifdef MULTI_EXPECT_STICKY_FAIL_EN
        chk("fail_latch", 64'(fail_latch_o), 64'(m_latched));
        chk("fail_ch", 64'(fail_ch_o), 64'(m_fail_ch));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ab(input int c, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a_i[c*WIDTH +: WIDTH] = av;
        b_i[c*WIDTH +: WIDTH] = bv;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        edge_n   = 0;
        rst_n    = 1'b0;
        arm_i    = '0;
        win_i    = '0;
        a_i      = '0;
        b_i      = '0;
        clr_i    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pass, window 0
        set_ab(0, 32'd5, 32'd5);
        win_i = 4'd0;
        arm_i = 4'b0001;
        step();
        chk("basic_busy", 64'(busy_o), 64'h1);
        arm_i = 4'b0000;
        step();
        chk("basic_pass", 64'(pass_o), 64'h1);
        chk("basic_pcnt", 64'(pass_cnt_o), 64'd1);
        step();

        // Timeout, window 3: fail on the 4th compare edge
        set_ab(1, 32'd4, 32'd5);
        win_i = 4'd3;
        arm_i = 4'b0010;
        step();
        arm_i = 4'b0000;
        repeat (3) step();
        chk("timeout_early", 64'(fail_o), 64'h0);
        step();
        chk("timeout_fail", 64'(fail_o), 64'h2);
        chk("timeout_fcnt", 64'(fail_cnt_o), 64'd1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;

        // Late match on ch2 at k+3
        set_ab(2, 32'd5, 32'd6);
        win_i = 4'd5;
        arm_i = 4'b0100;
        step();
        arm_i = 4'b0000;
        step();
        step();
        set_ab(2, 32'd5, 32'd5);
        step();
        chk("late_pass", 64'(pass_o), 64'h4);
        chk("late_pcnt", 64'(pass_cnt_o), 64'd1);
        step();

        // Concurrent: all four armed, ch0/ch2 match
        set_ab(0, 32'd7, 32'd7);
        set_ab(1, 32'd1, 32'd2);
        set_ab(2, 32'd9, 32'd9);
        set_ab(3, 32'd3, 32'd4);
        win_i = 4'd0;
        arm_i = 4'b1111;
        step();
        arm_i = 4'b0000;
        step();
        chk("conc_pass", 64'(pass_o), 64'h5);
        chk("conc_fail", 64'(fail_o), 64'hA);
        chk("conc_pcnt", 64'(pass_cnt_o), 64'd3);
        chk("conc_fcnt", 64'(fail_cnt_o), 64'd2);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;

        // Re-arm while busy: error pulse, original check still passes
        set_ab(0, 32'd1, 32'd2);
        win_i = 4'd2;
        arm_i = 4'b0001;
        step();
        step();
        chk("rearm_err", 64'(rearm_err_o), 64'h1);
        arm_i = 4'b0000;
        set_ab(0, 32'd3, 32'd3);
        step();
        chk("rearm_pass", 64'(pass_o), 64'h1);
        step();

        // Saturation at 15 after 20 more passes, then clear racing a pass
        set_ab(0, 32'd8, 32'd8);
        win_i = 4'd0;
        for (int i = 0; i < 20; i++) begin
            arm_i = 4'b0001;
            step();
            arm_i = 4'b0000;
            step();
        end
        chk("sat_pcnt", 64'(pass_cnt_o), 64'd15);
        arm_i = 4'b0001;
        step();
        arm_i = 4'b0000;
        clr_i = 1'b1;
        step();
        chk("clr_pulse", 64'(pass_o), 64'h1);
        chk("clr_pcnt", 64'(pass_cnt_o), 64'd0);
        clr_i = 1'b0;
        step();

        // Reset asserted mid-WAIT
        set_ab(1, 32'd1, 32'd2);
        win_i = 4'd10;
        arm_i = 4'b0010;
        step();
        arm_i = 4'b0000;
        step();
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_busy", 64'(busy_o), 64'h0);

`ifdef MULTI_EXPECT_STICKY_FAIL_EN
        // Sticky first-fail latch blocks later arms
        set_ab(3, 32'd1, 32'd2);
        win_i = 4'd0;
        arm_i = 4'b1000;
        step();
        arm_i = 4'b0000;
        step();
        chk("sticky_latch", 64'(fail_latch_o), 64'h1);
        chk("sticky_ch", 64'(fail_ch_o), 64'd3);
        set_ab(0, 32'd5, 32'd5);
        arm_i = 4'b0001;
        step();
        chk("sticky_blk_err", 64'(rearm_err_o), 64'h1);
        chk("sticky_blk_busy", 64'(busy_o), 64'h0);
        arm_i = 4'b0000;
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        step();
`endif

        // Randomized traffic checked against the model
        for (int i = 0; i < 600; i++) begin
            arm_i = NCH'($urandom & $urandom);
            win_i = WW'($urandom_range(0, MAX_WAIT));
            for (int c = 0; c < NCH; c++) begin
                set_ab(c, WIDTH'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 3)));
            end
            clr_i = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
